display_scan_ctrl: RTL

Sequential front end for the 4-digit seven-segment path. It generates the 2-bit digit scan index from a clock prescaler and double-buffers the displayed hex/point/LE data so that updates take effect only on a frame boundary. It also produces an optional inter-digit blanking pulse to suppress ghosting. It sits directly upstream of the combinational digit-select mux and drives its Hexs, Scan, Point and Les inputs.

---
 rtl/display_scan_ctrl.sv | 116 +++++++++++
 1 files changed

// File: rtl/display_scan_ctrl.sv
// Digit scan generator and frame-synchronous double buffer for the 4-digit seven-segment path.
// Optional inter-digit blanking is compiled in with `define SCAN_BLANK_EN.
module display_scan_ctrl #(
    parameter int DIV_MAX   = 49999,
    parameter int BLANK_CYC = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        load,
    input  logic [15:0] data_in,
    input  logic [3:0]  point_in,
    input  logic [3:0]  le_in,
    output logic [15:0] Hexs,
    output logic [3:0]  Point,
    output logic [3:0]  Les,
    output logic [1:0]  Scan,
    output logic        blank,
    output logic        frame_done,
    output logic        pending
);
    localparam int CW = ($clog2(DIV_MAX + 1) < 1) ? 1 : $clog2(DIV_MAX + 1);

    typedef struct packed {
        logic [15:0] hex;
        logic [3:0]  point;
        logic [3:0]  le;
    } disp_t;

    logic [CW-1:0] presc_q, presc_d;
    logic [1:0]    scan_q, scan_d;
    disp_t         shadow_q, shadow_d;
    disp_t         commit_q, commit_d;
    logic          pending_q, pending_d;
    logic          fd_q, fd_d;
    logic          tick, boundary;

    assign tick     = enable && (presc_q == CW'(DIV_MAX));
    assign boundary = tick && (scan_q == 2'd3);

    always_comb begin
        presc_d   = presc_q;
        scan_d    = scan_q;
        shadow_d  = shadow_q;
        commit_d  = commit_q;
        pending_d = pending_q;
        fd_d      = boundary;
        if (enable) begin
            presc_d = tick ? '0 : presc_q + CW'(1);
            if (tick) scan_d = scan_q + 2'd1;
        end
        // Commit uses the old shadow, so a load on the boundary edge waits a full frame.
        if (boundary && pending_q) begin
            commit_d  = shadow_q;
            pending_d = 1'b0;
        end
        if (load) begin
            shadow_d  = '{hex: data_in, point: point_in, le: le_in};
            pending_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q   <= '0;
            scan_q    <= '0;
            shadow_q  <= '0;
            commit_q  <= '0;
            pending_q <= 1'b0;
            fd_q      <= 1'b0;
        end else begin
            presc_q   <= presc_d;
            scan_q    <= scan_d;
            shadow_q  <= shadow_d;
            commit_q  <= commit_d;
            pending_q <= pending_d;
            fd_q      <= fd_d;
        end
    end

`ifdef SCAN_BLANK_EN
    localparam int BW = ($clog2(BLANK_CYC + 1) < 1) ? 1 : $clog2(BLANK_CYC + 1);

    logic [BW-1:0] bcnt_q, bcnt_d;
    logic          blank_q, blank_d;

    // Blank is registered from the next counter value so it rises with the Scan change.
    always_comb begin
        bcnt_d = bcnt_q;
        if (tick)             bcnt_d = BW'(BLANK_CYC);
        else if (bcnt_q != 0) bcnt_d = bcnt_q - BW'(1);
        blank_d = (bcnt_d != 0) || !enable;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcnt_q  <= '0;
            blank_q <= 1'b0;
        end else begin
            bcnt_q  <= bcnt_d;
            blank_q <= blank_d;
        end
    end

    assign blank = blank_q;
`else
    assign blank = 1'b0;
`endif

    assign Hexs       = commit_q.hex;
    assign Point      = commit_q.point;
    assign Les        = commit_q.le;
    assign Scan       = scan_q;
    assign frame_done = fd_q;
    assign pending    = pending_q;
endmodule
